// File: rtl/i2cpwm_pkg.sv
// -----------------------------------------------------------------------------
// i2cpwm_pkg
// Shared definitions for the I2C register target:
//   - state_t         : protocol FSM states
//   - NUM_REGS        : number of 8-bit duty registers
//   - REG_RESET_TABLE : packed reset values, register n in bits [8n+7:8n]
//   - reg_reset_val() : reset value lookup by register index
// -----------------------------------------------------------------------------
package i2cpwm_pkg;

    localparam int NUM_REGS = 8;
    localparam int PTR_W    = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_t;

    localparam logic [8*NUM_REGS-1:0] REG_RESET_TABLE = {
        8'hFF, 8'hC8, 8'h64, 8'h50, 8'h3C, 8'h28, 8'h14, 8'h01
    };

    function automatic logic [7:0] reg_reset_val(input logic [PTR_W-1:0] idx);
        return REG_RESET_TABLE[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// -----------------------------------------------------------------------------
// i2c_sync_edge
// Brings one asynchronous bus line into the clk domain through a STAGES-deep
// flop chain and flags its rising and falling edges.
// Ports:
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset (chain presets to 1 = bus idle)
//   i_async  : raw pad input
//   o_level  : synchronized level
//   o_rise   : one-cycle pulse on a 0->1 transition of o_level
//   o_fall   : one-cycle pulse on a 1->0 transition of o_level
// -----------------------------------------------------------------------------
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/i2c_reg_target.sv
// -----------------------------------------------------------------------------
// i2c_reg_target
// I2C target exposing eight 8-bit PWM duty registers. A write transaction
// sends a pointer byte followed by data bytes (pointer auto-increments, mod 8);
// a read transaction streams registers from the current pointer. The pointer
// persists between transactions. No clock stretching.
// Ports:
//   clk     : system clock, at least 16x the SCL bit rate
//   rst_n   : asynchronous active-low reset
//   scl_in  : SCL pad input (asynchronous)
//   sda_in  : SDA pad input (asynchronous)
//   sda_oe  : 1 pulls SDA low, 0 releases it
//   values  : register n in bits [8n+7:8n]
//   wr_stb  : one-cycle pulse when a register is written
//   wr_idx  : index of the written register, valid with wr_stb
// -----------------------------------------------------------------------------
module i2c_reg_target
    import i2cpwm_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [63:0] values,
    output logic        wr_stb,
    output logic [2:0]  wr_idx
);

    logic w_scl;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_sda;
    logic w_sda_rise;
    logic w_sda_fall;
    logic w_start;
    logic w_stop;
    logic w_bit_in;
    logic w_byte_end;
    logic [7:0] w_rd_byte;

    state_t         r_state;
    logic [3:0]     r_bitcnt;
    logic [7:0]     r_shift;
    logic [PTR_W-1:0] r_ptr;
    logic           r_sda_oe;
    logic           r_wr_stb;
    logic [PTR_W-1:0] r_wr_idx;
    logic           r_mack;
    logic [7:0]     r_regs [NUM_REGS];

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_async (scl_in),
        .o_level (w_scl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_async (sda_in),
        .o_level (w_sda),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    // Both lines see identical synchronizer latency, so an SDA edge while the
    // synchronized SCL is high is a genuine START/STOP condition.
    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;

    // Receive bit on SCL rise; a byte is complete on the SCL fall after bit 8.
    assign w_bit_in   = w_scl_rise & (r_bitcnt < 4'd8);
    assign w_byte_end = w_scl_fall & (r_bitcnt == 4'd8);

    assign w_rd_byte = r_regs[r_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= 4'd0;
            r_shift  <= 8'd0;
            r_ptr    <= '0;
            r_sda_oe <= 1'b0;
            r_wr_stb <= 1'b0;
            r_wr_idx <= '0;
            r_mack   <= 1'b1;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= reg_reset_val(PTR_W'(i));
            end
        end else begin
            r_wr_stb <= 1'b0;
            if (w_stop) begin
                r_state  <= ST_IDLE;
                r_sda_oe <= 1'b0;
                r_bitcnt <= 4'd0;
            end else if (w_start) begin
                r_state  <= ST_ADDR;
                r_sda_oe <= 1'b0;
                r_bitcnt <= 4'd0;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (w_bit_in) begin
                            r_shift  <= {r_shift[6:0], w_sda};
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_byte_end) begin
                            r_bitcnt <= 4'd0;
                            if (r_shift[7:1] == DEV_ADDR) begin
                                r_state  <= ST_ADDR_ACK;
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_state  <= ST_IGNORE;
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        // r_shift still holds the address byte; bit 0 is R/W.
                        if (w_scl_fall) begin
                            if (r_shift[0]) begin
                                r_state  <= ST_RDATA;
                                r_shift  <= w_rd_byte;
                                r_sda_oe <= ~w_rd_byte[7];
                                r_ptr    <= r_ptr + 1'b1;
                            end else begin
                                r_state  <= ST_PTR;
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end

                    ST_PTR: begin
                        if (w_bit_in) begin
                            r_shift  <= {r_shift[6:0], w_sda};
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_byte_end) begin
                            r_bitcnt <= 4'd0;
                            r_ptr    <= r_shift[PTR_W-1:0];
                            r_state  <= ST_PTR_ACK;
                            r_sda_oe <= 1'b1;
                        end
                    end

                    ST_PTR_ACK: begin
                        if (w_scl_fall) begin
                            r_state  <= ST_WDATA;
                            r_sda_oe <= 1'b0;
                        end
                    end

                    ST_WDATA: begin
                        // Registers change only on a completed byte, so an
                        // aborted byte leaves both registers and ptr intact.
                        if (w_bit_in) begin
                            r_shift  <= {r_shift[6:0], w_sda};
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_byte_end) begin
                            r_bitcnt      <= 4'd0;
                            r_regs[r_ptr] <= r_shift;
                            r_wr_stb      <= 1'b1;
                            r_wr_idx      <= r_ptr;
                            r_ptr         <= r_ptr + 1'b1;
                            r_state       <= ST_WDATA_ACK;
                            r_sda_oe      <= 1'b1;
                        end
                    end

                    ST_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            r_state  <= ST_WDATA;
                            r_sda_oe <= 1'b0;
                        end
                    end

                    ST_RDATA: begin
                        // MSB was already driven when the byte was loaded;
                        // each later fall presents the next bit.
                        if (w_scl_rise && (r_bitcnt < 4'd8)) begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 4'd8) begin
                                r_bitcnt <= 4'd0;
                                r_sda_oe <= 1'b0;
                                r_state  <= ST_RDATA_ACK;
                            end else begin
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_sda_oe <= ~r_shift[6];
                            end
                        end
                    end

                    ST_RDATA_ACK: begin
                        if (w_scl_rise) begin
                            r_mack <= w_sda;
                        end else if (w_scl_fall) begin
                            if (!r_mack) begin
                                r_state  <= ST_RDATA;
                                r_shift  <= w_rd_byte;
                                r_sda_oe <= ~w_rd_byte[7];
                                r_ptr    <= r_ptr + 1'b1;
                            end else begin
                                r_state  <= ST_IGNORE;
                            end
                        end
                    end

                    ST_IDLE, ST_IGNORE: begin
                        r_sda_oe <= 1'b0;
                    end

                    default: begin
                        r_state  <= ST_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_values
        assign values[8*g +: 8] = r_regs[g];
    end

    assign sda_oe = r_sda_oe;
    assign wr_stb = r_wr_stb;
    assign wr_idx = r_wr_idx;

endmodule

// File: doc/i2c_reg_target.md
I2C_REG_TARGET -- requirements
Module: i2c_reg_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h42: 7-bit I2C target address.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on SCL/SDA inputs, minimum 2.
REQ-003 clk  input  1  system clock; must run at least 16x the SCL bit rate.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 scl_in  input  1  SCL pad input; asynchronous to clk.
REQ-006 sda_in  input  1  SDA pad input; asynchronous to clk.
REQ-007 sda_oe  output  1  SDA open-drain pull-low enable; 1 drives the pad low, 0 releases it.
REQ-008 values  output  64  eight 8-bit PWM duty registers; register n occupies bits [8n+7:8n].
REQ-009 wr_stb  output  1  single-cycle pulse when a register is written.
REQ-010 wr_idx  output  3  index of the register written; valid while wr_stb=1.

Function
REQ-011 SCL and SDA SHALL each pass through a SYNC_STAGES flop chain, followed by rise/fall edge detection.
REQ-012 START (SDA fall while SCL=1) SHALL enter ADDR from any state, including mid-byte; this covers repeated START.
REQ-013 STOP (SDA rise while SCL=1) SHALL enter IDLE from any state and release sda_oe within 1 clk.
REQ-014 The FSM SHALL have these states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-015 Receive bits SHALL be sampled on SCL rising edges, MSB first; drive changes SHALL occur only on SCL falling edges.
REQ-016 ADDR: after 8 bits, if addr[7:1]==DEV_ADDR, the block SHALL go to ADDR_ACK; otherwise it SHALL go to IGNORE, leaving sda_oe=0 until the next START or STOP.
REQ-017 ACK: sda_oe SHALL assert on the SCL fall that ends bit 8 and deassert on the SCL fall that ends bit 9.
REQ-018 After ADDR_ACK, R/W=0 SHALL lead to PTR and R/W=1 SHALL lead to RDATA.
REQ-019 PTR byte: ptr SHALL load from byte[2:0]; bits [7:3] SHALL be ignored; the byte SHALL be ACKed; then the FSM SHALL go to WDATA.
REQ-020 WDATA byte: reg[ptr] SHALL update, with wr_stb=1 and wr_idx=ptr, in the clk cycle after the SCL fall that ends bit 8.
REQ-021 After each WDATA byte, ptr SHALL increment modulo 8, so 7 wraps to 0. Every byte SHALL be ACKed, then the FSM SHALL return to WDATA.
REQ-022 RDATA: the shifter SHALL load reg[ptr] and ptr SHALL increment modulo 8. Each bit SHALL be driven as sda_oe = ~bit, and the line SHALL be released during the master's ACK slot.
REQ-023 RDATA_ACK: master ACK (SDA=0) SHALL lead back to RDATA with the next register. Master NACK SHALL lead to IGNORE.
REQ-024 ptr SHALL persist across transactions, so a write of only the PTR byte followed by repeated START and read returns reg[ptr].
REQ-025 A write byte aborted by START or STOP before bit 8 completes SHALL leave registers and ptr unchanged.
REQ-026 No clock stretching SHALL occur; scl is never driven.
REQ-027 values SHALL change only through REQ-020 or reset.

Reset
REQ-028 On rst_n=0, asynchronously: state=IDLE, sda_oe=0, wr_stb=0, wr_idx=0, ptr=0, bit counter=0, and synchronizer flops=1 (bus idle).
REQ-029 Reset register values SHALL be: reg0..7 = 0x01, 0x14, 0x28, 0x3C, 0x50, 0x64, 0xC8, 0xFF.
REQ-030 Reset asserted mid-transaction SHALL release SDA immediately; after deassertion the block SHALL ignore bus activity until the next START.

Structure
REQ-031 A shared package i2cpwm_pkg SHALL hold the FSM state enum, the NUM_REGS=8 constant, and the reset-value table.
REQ-032 A sub-module i2c_sync_edge (synchronizer plus rise/fall detect) SHALL be instantiated twice, once for SCL and once for SDA.
REQ-033 The top SHALL connect values directly to the eight pwm_module value inputs.

Verification
REQ-034 Reset check: read values after reset -> 0x01..0xFF exactly per REQ-029; sda_oe=0.
REQ-035 Write check: START, 0x84, 0x03, 0xAA, 0xBB, STOP -> 4 ACKs; reg3=0xAA and reg4=0xBB; wr_stb pulses with wr_idx 3 then 4.
REQ-036 Wrap check: ptr=0x07, write 0x11, 0x22 -> reg7=0x11, reg0=0x22.
REQ-037 Repeated-START read: START, 0x84, 0x06, Sr, 0x85, read 3 bytes (ACK, ACK, NACK), STOP -> returns 0xC8, 0xFF, reg0; sda_oe released after the NACK.
REQ-038 Wrong address: START, 0x90, data -> sda_oe stays 0 throughout; values unchanged.
REQ-039 Abort: START, 0x84, 0x02, then STOP after 4 bits of 0xF0 -> reg2 unchanged, no wr_stb; a subsequent transaction works normally.
